// File: rtl/generic_ram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : generic_ram_loader
//  Purpose  : Collects a serial bit stream (LSB of word 0 first) into
//             gDataWidth-bit words and writes them to consecutive memory
//             addresses through a valid/ready write port. A load starts on
//             iStart and ends after gDepth words or on iFlush.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iClock      in   1     clock, rising edge
//    iReset      in   1     asynchronous active-low reset
//    iStart      in   1     one-cycle load request (honoured in IDLE/DONE)
//    iFlush      in   1     end-of-stream, terminates the load early
//    iBitValid   in   1     serial bit present
//    iBit        in   1     serial bit
//    oBitReady   out  1     loader accepts a bit this cycle
//    oWrValid    out  1     memory write request
//    iWrReady    in   1     memory accepts the write
//    oWrAddress  out  AW    current write address
//    oWrData     out  DW    write data (zero outside WRITE)
//    oBusy       out  1     load in progress (COLLECT or WRITE)
//    oDone       out  1     load finished
//    oWordCount  out  AW+1  words written since the last iStart
// ============================================================================
module generic_ram_loader #(
  parameter int gAddressWidth = 6,
  parameter int gDataWidth    = 8,
  parameter int gDepth        = 2**gAddressWidth
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iStart,
  input  logic                     iFlush,
  input  logic                     iBitValid,
  input  logic                     iBit,
  output logic                     oBitReady,
  output logic                     oWrValid,
  input  logic                     iWrReady,
  output logic [gAddressWidth-1:0] oWrAddress,
  output logic [gDataWidth-1:0]    oWrData,
  output logic                     oBusy,
  output logic                     oDone,
  output logic [gAddressWidth:0]   oWordCount
);

  localparam int CNT_W = (gDataWidth > 1) ? $clog2(gDataWidth) : 1;
  localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(gDataWidth - 1);
  localparam logic [gAddressWidth-1:0] ADDR_LAST = gAddressWidth'(gDepth - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;     // next bit position inside the word
  logic [gDataWidth-1:0]   shift_word;  // partially assembled word
  logic                    last_word;   // word being written ends the load

  logic                    bit_take;
  logic                    word_full;
  logic                    have_bits;
  logic [gDataWidth-1:0]   word_merged;

  // The word including any bit accepted this cycle; a flush in the same
  // cycle must see that bit, so the write data comes from here.
  always_comb begin
    bit_take    = iBitValid & oBitReady;
    word_merged = shift_word;
    if (bit_take) begin
      word_merged = shift_word | (gDataWidth'(iBit) << bit_cnt);
    end
    word_full = bit_take && (bit_cnt == CNT_LAST);
    have_bits = bit_take || (bit_cnt != '0);
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shift_word <= '0;
      last_word  <= 1'b0;
      oBitReady  <= 1'b0;
      oWrValid   <= 1'b0;
      oWrAddress <= '0;
      oWrData    <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oWordCount <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            state      <= S_COLLECT;
            bit_cnt    <= '0;
            shift_word <= '0;
            last_word  <= 1'b0;
            oWrAddress <= '0;
            oWordCount <= '0;
            oBitReady  <= 1'b1;
            oBusy      <= 1'b1;
            oDone      <= 1'b0;
          end
        end

        S_COLLECT: begin
          if (bit_take) begin
            shift_word <= word_merged;
            bit_cnt    <= bit_cnt + CNT_W'(1);
          end
          if (word_full || (iFlush && have_bits)) begin
            // Unfilled upper bits are already zero because the word is
            // cleared whenever a new word starts.
            state     <= S_WRITE;
            last_word <= iFlush;
            oBitReady <= 1'b0;
            oWrValid  <= 1'b1;
            oWrData   <= word_merged;
          end else if (iFlush) begin
            state     <= S_DONE;
            oBitReady <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b1;
          end
        end

        S_WRITE: begin
          if (iWrReady) begin
            oWordCount <= oWordCount + {{gAddressWidth{1'b0}}, 1'b1};
            oWrValid   <= 1'b0;
            oWrData    <= '0;
            // The last address is a hard stop; the address never wraps.
            if (last_word || (oWrAddress == ADDR_LAST)) begin
              state <= S_DONE;
              oBusy <= 1'b0;
              oDone <= 1'b1;
            end else begin
              state      <= S_COLLECT;
              oWrAddress <= oWrAddress + gAddressWidth'(1);
              bit_cnt    <= '0;
              shift_word <= '0;
              oBitReady  <= 1'b1;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          oBitReady <= 1'b0;
          oWrValid  <= 1'b0;
          oWrData   <= '0;
          oBusy     <= 1'b0;
          oDone     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_generic_ram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_generic_ram_loader
//  Purpose  : Self-checking bench for generic_ram_loader. Two instances
//             (depth 64 and depth 4) share one stimulus stream; each is
//             compared every cycle against a behavioural model, and the
//             write traffic is compared against directed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_generic_ram_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, flush, bit_valid, bit_in, wr_ready;
  logic       br0, wv0, busy0, done0, br1, wv1, busy1, done1;
  logic [5:0] a0, a1;
  logic [7:0] d0, d1;
  logic [6:0] c0, c1;

  generic_ram_loader #(.gAddressWidth(6), .gDataWidth(8)) dut0 (
    .iClock(clk), .iReset(rst_n), .iStart(start), .iFlush(flush),
    .iBitValid(bit_valid), .iBit(bit_in), .oBitReady(br0), .oWrValid(wv0),
    .iWrReady(wr_ready), .oWrAddress(a0), .oWrData(d0), .oBusy(busy0),
    .oDone(done0), .oWordCount(c0)
  );

  generic_ram_loader #(.gAddressWidth(6), .gDataWidth(8), .gDepth(4)) dut1 (
    .iClock(clk), .iReset(rst_n), .iStart(start), .iFlush(flush),
    .iBitValid(bit_valid), .iBit(bit_in), .oBitReady(br1), .oWrValid(wv1),
    .iWrReady(wr_ready), .oWrAddress(a1), .oWrData(d1), .oBusy(busy1),
    .oDone(done1), .oWordCount(c1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 collecting, 2 writing, 3 done.
  int depth_of [2] = '{64, 4};
  int m_ph [2];
  int m_addr [2];
  int m_nb [2];
  int m_word [2];
  int m_wdata [2];
  int m_cnt [2];
  bit m_last [2];
  bit m_acc [2];

  // Writes observed on each instance, packed as address*256+data.
  int obs0 [$];
  int obs1 [$];
  logic s_wv [2];
  int   s_a [2];
  int   s_d [2];

  bit stream [$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_addr[k] = 0; m_nb[k] = 0; m_word[k] = 0;
      m_wdata[k] = 0; m_cnt[k] = 0; m_last[k] = 0; m_acc[k] = 0;
      s_wv[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    m_acc[k] = 0;
    if (!rst_n) begin
      m_ph[k] = 0; m_addr[k] = 0; m_nb[k] = 0; m_word[k] = 0;
      m_wdata[k] = 0; m_cnt[k] = 0; m_last[k] = 0;
      return;
    end
    case (m_ph[k])
      0, 3: if (start) begin
        m_ph[k] = 1; m_addr[k] = 0; m_nb[k] = 0; m_word[k] = 0;
        m_cnt[k] = 0; m_last[k] = 0;
      end
      1: begin
        if (bit_valid) begin
          m_word[k] = m_word[k] | (int'(bit_in) << m_nb[k]);
          m_nb[k]++;
          m_acc[k] = 1;
        end
        if (m_nb[k] == 8 || (flush && m_nb[k] > 0)) begin
          m_wdata[k] = m_word[k]; m_last[k] = flush; m_ph[k] = 2;
        end else if (flush) begin
          m_ph[k] = 3;
        end
      end
      2: if (wr_ready) begin
        m_cnt[k]++;
        if (m_last[k] || m_addr[k] == depth_of[k] - 1) m_ph[k] = 3;
        else begin
          m_addr[k]++; m_nb[k] = 0; m_word[k] = 0; m_ph[k] = 1;
        end
      end
      default: m_ph[k] = 0;
    endcase
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      logic g_br, g_wv, g_busy, g_done;
      int   g_a, g_d, g_c;
      g_br   = (k == 0) ? br0 : br1;
      g_wv   = (k == 0) ? wv0 : wv1;
      g_busy = (k == 0) ? busy0 : busy1;
      g_done = (k == 0) ? done0 : done1;
      g_a    = (k == 0) ? int'(a0) : int'(a1);
      g_d    = (k == 0) ? int'(d0) : int'(d1);
      g_c    = (k == 0) ? int'(c0) : int'(c1);
      check_val($sformatf("bit_ready%0d", k), g_br, m_ph[k] == 1);
      check_val($sformatf("wr_valid%0d", k), g_wv, m_ph[k] == 2);
      check_val($sformatf("wr_addr%0d", k), g_a, m_addr[k]);
      check_val($sformatf("wr_data%0d", k), g_d, (m_ph[k] == 2) ? m_wdata[k] : 0);
      check_val($sformatf("busy%0d", k), g_busy, m_ph[k] == 1 || m_ph[k] == 2);
      check_val($sformatf("done%0d", k), g_done, m_ph[k] == 3);
      check_val($sformatf("word_count%0d", k), g_c, m_cnt[k]);
      s_wv[k] = g_wv; s_a[k] = g_a; s_d[k] = g_d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && wr_ready) begin
      if (s_wv[0]) obs0.push_back(s_a[0] * 256 + s_d[0]);
      if (s_wv[1]) obs1.push_back(s_a[1] * 256 + s_d[1]);
    end
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare();
  endtask

  task automatic idle_ticks(input int n);
    bit_valid = 1'b0; flush = 1'b0; start = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ends any load in progress on both instances.
  task automatic drain();
    int n = 0;
    bit_valid = 1'b0; start = 1'b0; wr_ready = 1'b1; flush = 1'b1;
    while (!((m_ph[0] == 0 || m_ph[0] == 3) && (m_ph[1] == 0 || m_ph[1] == 3)) && n < 200) begin
      tick();
      n++;
    end
    flush = 1'b0;
    if (n >= 200) check_val("drain_timeout", 1, 0);
  endtask

  task automatic push_word(input int w);
    for (int i = 0; i < 8; i++) stream.push_back(bit'((w >> i) & 1));
  endtask

  // Offers the stream; a bit is retired when the depth-64 model accepts it.
  task automatic feed(input int rdy_pct, input int val_pct);
    int n = 0;
    while (stream.size() > 0 && n < 5000) begin
      bit_valid = ($urandom_range(99) < val_pct);
      bit_in    = stream[0];
      wr_ready  = ($urandom_range(99) < rdy_pct);
      tick();
      if (m_acc[0]) void'(stream.pop_front());
      n++;
    end
    bit_valid = 1'b0;
    if (stream.size() > 0) begin
      check_val("feed_timeout", stream.size(), 0);
      stream.delete();
    end
  endtask

  int rnd_words [5];

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; bit_valid = 1'b0;
    bit_in = 1'b0; wr_ready = 1'b0;
    model_reset();

    // Reset state, then idle without a start.
    @(negedge clk);
    compare();
    tick();
    rst_n = 1'b1;
    idle_ticks(3);

    // Basic two-word load.
    obs0.delete(); obs1.delete();
    do_start();
    push_word(8'hA5); push_word(8'h3C);
    feed(100, 100);
    idle_ticks(3);
    check_val("basic_nwr", obs0.size(), 2);
    if (obs0.size() == 2) begin
      check_val("basic_w0", obs0[0], 8'hA5);
      check_val("basic_w1", obs0[1], 256 + 8'h3C);
    end
    check_val("basic_cnt", c0, 2);

    // Backpressure: three cycles of iWrReady low with a bit on offer.
    drain();
    obs0.delete(); obs1.delete();
    do_start();
    push_word(8'h5A);
    feed(0, 100);
    bit_valid = 1'b1; bit_in = 1'b1; wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_val("bp_valid", wv0, 1);
    check_val("bp_addr", a0, 0);
    check_val("bp_data", d0, 8'h5A);
    check_val("bp_ready", br0, 0);
    bit_valid = 1'b0; wr_ready = 1'b1;
    tick();
    check_val("bp_nwr", obs0.size(), 1);
    if (obs0.size() == 1) check_val("bp_w0", obs0[0], 8'h5A);

    // Flush after three bits, then flush with no bits.
    drain();
    obs0.delete(); obs1.delete();
    do_start();
    stream.push_back(1'b1); stream.push_back(1'b0); stream.push_back(1'b1);
    feed(100, 100);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_ticks(2);
    check_val("flush_nwr", obs0.size(), 1);
    if (obs0.size() == 1) check_val("flush_w0", obs0[0], 8'h05);
    check_val("flush_done", done0, 1);
    check_val("flush_cnt", c0, 1);
    do_start();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_ticks(2);
    check_val("flush0_nwr", obs0.size(), 1);
    check_val("flush0_done", done0, 1);
    check_val("flush0_cnt", c0, 0);

    // Depth limit on the depth-4 instance: 40 bits offered.
    drain();
    obs0.delete(); obs1.delete();
    do_start();
    for (int i = 0; i < 5; i++) begin
      rnd_words[i] = int'($urandom_range(255));
      push_word(rnd_words[i]);
    end
    feed(100, 100);
    idle_ticks(3);
    check_val("depth_nwr", obs1.size(), 4);
    if (obs1.size() == 4) begin
      for (int i = 0; i < 4; i++) check_val($sformatf("depth_w%0d", i), obs1[i], i * 256 + rnd_words[i]);
    end
    check_val("depth_done", done1, 1);
    check_val("depth_ready", br1, 0);
    check_val("depth_cnt", c1, 4);
    check_val("depth64_nwr", obs0.size(), 5);

    // Content pattern: bit i set when i mod 9 == 0.
    drain();
    obs0.delete(); obs1.delete();
    do_start();
    for (int i = 0; i < 64; i++) stream.push_back(bit'((i % 9) == 0));
    feed(100, 100);
    idle_ticks(3);
    check_val("pat_nwr", obs0.size(), 8);
    if (obs0.size() == 8) begin
      for (int i = 0; i < 8; i++) check_val($sformatf("pat_w%0d", i), obs0[i], i * 256 + (1 << i));
    end

    // Randomized traffic with random starts, flushes, gaps and backpressure.
    drain();
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(19) == 0);
      flush     = ($urandom_range(24) == 0);
      bit_valid = ($urandom_range(3) != 0);
      bit_in    = 1'($urandom_range(1));
      wr_ready  = ($urandom_range(2) != 0);
      tick();
    end

    // Reset in the middle of word 1.
    drain();
    obs0.delete(); obs1.delete();
    do_start();
    push_word(8'hC3);
    stream.push_back(1'b1); stream.push_back(1'b1); stream.push_back(1'b0);
    feed(100, 100);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_ready", br0, 0);
    check_val("rst_valid", wv0, 0);
    check_val("rst_addr", a0, 0);
    check_val("rst_data", d0, 0);
    check_val("rst_busy", busy0, 0);
    check_val("rst_done", done0, 0);
    check_val("rst_cnt", c0, 0);
    check_val("rst_busy1", busy1, 0);
    model_reset();
    obs0.delete(); obs1.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    idle_ticks(2);
    check_val("rst_stays_idle", busy0, 0);
    do_start();
    push_word(8'h96);
    feed(100, 100);
    idle_ticks(3);
    check_val("rst_reload_nwr", obs0.size(), 1);
    if (obs0.size() == 1) check_val("rst_reload_w0", obs0[0], 8'h96);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
